// File: rtl/pipe_ctrl.sv
// pipe_ctrl: central pipeline controller for the 4-stage IF/ID/EX/MEM core.
//
// Resolves bus-busy, load-use hazard, exception, ERET, external interrupt and
// HALT by fixed priority. It generates per-stage stall/flush controls and the
// redirect PC, and holds the exception state (IntEn, PrevIntEn, EPC, ExpCode).
//
// Ports:
//   clk, reset_                   clock, asynchronous active-low reset
//   IFBusy, MemBusy               bus not ready; the whole pipe holds
//   LoadHazard                    ID depends on an EX load; a bubble goes into EX
//   MemEn, MemPC, MemExp,
//   MemExpCode, MemEret, MemHalt  MEM-stage instruction and its events
//   IrqReq                        level external interrupt request
//   CtrlWe, CtrlAddr, CtrlWrData  control-register write port
//   CtrlRdData                    combinational control-register read
//   {IF,ID,EX,MEM}Stall/Flush     per-stage hold / load-bubble controls
//   NewPC                         redirect target, valid while IFFlush=1
//   IntEn, Halted                 interrupt enable, core halted
//   state_dbg                     FSM state (0=RUN, 1=REDIR, 2=HALT)
//
// Handshake: none. Stall/Flush/NewPC are combinational from the state and the
// inputs. The upstream stages must act on them in the same cycle.

module pipe_ctrl #(
  parameter int              ADDR_W      = 30,
  parameter int              DATA_W      = 32,
  parameter logic [ADDR_W-1:0] TRAP_VECTOR = 30'h0000_0040,
  parameter logic [2:0]      EXP_IRQ     = 3'd1
) (
  input  logic              clk,
  input  logic              reset_,
  input  logic              IFBusy,
  input  logic              MemBusy,
  input  logic              LoadHazard,
  input  logic              MemEn,
  input  logic [ADDR_W-1:0] MemPC,
  input  logic              MemExp,
  input  logic [2:0]        MemExpCode,
  input  logic              MemEret,
  input  logic              MemHalt,
  input  logic              IrqReq,
  input  logic              CtrlWe,
  input  logic [1:0]        CtrlAddr,
  input  logic [DATA_W-1:0] CtrlWrData,
  output logic [DATA_W-1:0] CtrlRdData,
  output logic              IFStall,
  output logic              IDStall,
  output logic              EXStall,
  output logic              MEMStall,
  output logic              IFFlush,
  output logic              IDFlush,
  output logic              EXFlush,
  output logic              MEMFlush,
  output logic [ADDR_W-1:0] NewPC,
  output logic              IntEn,
  output logic              Halted,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    REDIR = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic              int_en, prev_int_en;
  logic [ADDR_W-1:0] epc, halt_pc;
  logic [2:0]        exp_code;

  // Bits {IF,ID,EX,MEM}.
  logic [3:0]        stall_c, flush_c;
  logic [ADDR_W-1:0] new_pc_c;
  logic              ev_trap, ev_eret, ev_halt, ctrl_ok;
  logic [2:0]        ev_code;
  logic [ADDR_W-1:0] ev_epc;
  logic              is_run, busy;

  assign busy   = IFBusy | MemBusy;
  assign is_run = (state == RUN);

  always_comb begin
    stall_c   = 4'b0000;
    flush_c   = 4'b0000;
    new_pc_c  = '0;
    state_nxt = state;
    ev_trap   = 1'b0;
    ev_eret   = 1'b0;
    ev_halt   = 1'b0;
    ev_code   = 3'd0;
    ev_epc    = '0;
    ctrl_ok   = 1'b0;
    if (state == HALT) begin
      // Fetch is frozen. Later stages drain as bubbles until an interrupt wakes the core.
      stall_c = 4'b1000;
      flush_c = 4'b0111;
      ctrl_ok = CtrlWe;
      if (IrqReq && int_en) begin
        stall_c   = 4'b0000;
        flush_c   = 4'b1111;
        new_pc_c  = TRAP_VECTOR;
        ev_trap   = 1'b1;
        ev_code   = EXP_IRQ;
        ev_epc    = halt_pc;
        ctrl_ok   = 1'b0;
        state_nxt = REDIR;
      end
    end else begin
      // RUN and REDIR share the rules. REDIR masks ERET, IRQ and HALT and lasts one cycle.
      state_nxt = RUN;
      if (busy) begin
        stall_c = 4'b1111;
      end else if (MemEn && MemExp) begin
        flush_c   = 4'b1111;
        new_pc_c  = TRAP_VECTOR;
        ev_trap   = 1'b1;
        ev_code   = MemExpCode;
        ev_epc    = MemPC;
        state_nxt = REDIR;
      end else if (is_run && MemEn && MemEret) begin
        flush_c   = 4'b1111;
        new_pc_c  = epc;
        ev_eret   = 1'b1;
        state_nxt = REDIR;
      end else if (is_run && MemEn && IrqReq && int_en) begin
        flush_c   = 4'b1111;
        new_pc_c  = TRAP_VECTOR;
        ev_trap   = 1'b1;
        ev_code   = EXP_IRQ;
        ev_epc    = MemPC;
        state_nxt = REDIR;
      end else if (is_run && MemEn && MemHalt) begin
        // The HALT instruction itself retires. Younger stages are squashed.
        flush_c   = 4'b1110;
        new_pc_c  = MemPC + {{(ADDR_W-1){1'b0}}, 1'b1};
        ev_halt   = 1'b1;
        state_nxt = HALT;
      end else begin
        if (LoadHazard) begin
          stall_c = 4'b1100;
          flush_c = 4'b0100;
        end
        ctrl_ok = CtrlWe;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state       <= RUN;
      int_en      <= 1'b0;
      prev_int_en <= 1'b0;
      epc         <= '0;
      exp_code    <= 3'd0;
      halt_pc     <= '0;
    end else begin
      state <= state_nxt;
      if (ev_halt) halt_pc <= new_pc_c;
      if (ev_trap) begin
        epc         <= ev_epc;
        exp_code    <= ev_code;
        prev_int_en <= int_en;
        int_en      <= 1'b0;
      end else if (ev_eret) begin
        int_en <= prev_int_en;
      end else if (ctrl_ok) begin
        case (CtrlAddr)
          2'd0: begin
            int_en      <= CtrlWrData[0];
            prev_int_en <= CtrlWrData[1];
          end
          2'd1:    epc      <= CtrlWrData[ADDR_W-1:0];
          2'd2:    exp_code <= CtrlWrData[2:0];
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    CtrlRdData = '0;
    case (CtrlAddr)
      2'd0:    CtrlRdData = {{(DATA_W-2){1'b0}}, prev_int_en, int_en};
      2'd1:    CtrlRdData = {{(DATA_W-ADDR_W){1'b0}}, epc};
      2'd2:    CtrlRdData = {{(DATA_W-3){1'b0}}, exp_code};
      default: CtrlRdData = '0;
    endcase
  end

  // The control outputs are forced quiet while reset is asserted, whatever the inputs.
  assign {IFStall, IDStall, EXStall, MEMStall} = stall_c & {4{reset_}};
  assign {IFFlush, IDFlush, EXFlush, MEMFlush} = flush_c & {4{reset_}};
  assign NewPC     = new_pc_c & {ADDR_W{reset_}};
  assign IntEn     = int_en;
  assign Halted    = (state == HALT);
  assign state_dbg = state;

  logic unused_wr_bits;
  assign unused_wr_bits = &{1'b0, CtrlWrData[DATA_W-1:ADDR_W]};

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        reset_;
  logic        IFBusy, MemBusy, LoadHazard, MemEn, MemExp, MemEret, MemHalt, IrqReq, CtrlWe;
  logic [29:0] MemPC;
  logic [2:0]  MemExpCode;
  logic [1:0]  CtrlAddr;
  logic [31:0] CtrlWrData, CtrlRdData;
  logic        IFStall, IDStall, EXStall, MEMStall, IFFlush, IDFlush, EXFlush, MEMFlush;
  logic [29:0] NewPC;
  logic        IntEn, Halted;
  logic [1:0]  state_dbg;

  int pass_cnt = 0;
  int total_cnt = 0;

  // clock / reset
  always #5 clk = ~clk;

  pipe_ctrl dut (
    .clk(clk), .reset_(reset_), .IFBusy(IFBusy), .MemBusy(MemBusy), .LoadHazard(LoadHazard),
    .MemEn(MemEn), .MemPC(MemPC), .MemExp(MemExp), .MemExpCode(MemExpCode), .MemEret(MemEret),
    .MemHalt(MemHalt), .IrqReq(IrqReq), .CtrlWe(CtrlWe), .CtrlAddr(CtrlAddr),
    .CtrlWrData(CtrlWrData), .CtrlRdData(CtrlRdData), .IFStall(IFStall), .IDStall(IDStall),
    .EXStall(EXStall), .MEMStall(MEMStall), .IFFlush(IFFlush), .IDFlush(IDFlush),
    .EXFlush(EXFlush), .MEMFlush(MEMFlush), .NewPC(NewPC), .IntEn(IntEn), .Halted(Halted),
    .state_dbg(state_dbg)
  );

  wire [3:0] stall = {IFStall, IDStall, EXStall, MEMStall};
  wire [3:0] flush = {IFFlush, IDFlush, EXFlush, MEMFlush};

  // checking
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // driver tasks
  task automatic clear_inputs();
    IFBusy = 0; MemBusy = 0; LoadHazard = 0; MemEn = 0; MemExp = 0; MemEret = 0;
    MemHalt = 0; IrqReq = 0; CtrlWe = 0; MemPC = '0; MemExpCode = 0; CtrlAddr = 0;
    CtrlWrData = '0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic ctrl_write(input logic [1:0] a, input logic [31:0] d);
    clear_inputs();
    CtrlWe = 1; CtrlAddr = a; CtrlWrData = d;
    step();
    clear_inputs();
  endtask

  task automatic ctrl_read(input string tag, input logic [1:0] a, input logic [31:0] exp);
    CtrlAddr = a; #1;
    check(tag, CtrlRdData, exp);
  endtask

  initial begin
    clear_inputs();
    reset_ = 0;
    #12;
    check("rst_stall", {28'd0, stall}, 0);
    check("rst_flush", {28'd0, flush}, 0);
    check("rst_newpc", {2'd0, NewPC}, 0);
    check("rst_halted", {31'd0, Halted}, 0);
    reset_ = 1;
    step();

    // Reset mid-run with IntEn=1, EPC=5.
    ctrl_write(2'd0, 32'h1);
    ctrl_write(2'd1, 32'h5);
    check("pre_inten", {31'd0, IntEn}, 1);
    ctrl_read("pre_epc", 2'd1, 32'h5);
    MemEn = 1; MemExp = 1; MemExpCode = 3'd2; IFBusy = 1;
    reset_ = 0; #1;
    check("midrst_flush", {28'd0, flush}, 0);
    check("midrst_stall", {28'd0, stall}, 0);
    check("midrst_inten", {31'd0, IntEn}, 0);
    ctrl_read("midrst_epc", 2'd1, 0);
    check("midrst_state", {30'd0, state_dbg}, 0);
    clear_inputs();
    step();
    reset_ = 1;
    step();

    // Exception with IntEn=1.
    ctrl_write(2'd0, 32'h1);
    MemEn = 1; MemExp = 1; MemExpCode = 3'd3; MemPC = 30'h100;
    CtrlWe = 1; CtrlAddr = 2'd1; CtrlWrData = 32'h7;  // dropped: event wins
    #1;
    check("exc_flush", {28'd0, flush}, 4'hF);
    check("exc_stall", {28'd0, stall}, 0);
    check("exc_newpc", {2'd0, NewPC}, 32'h40);
    step();
    clear_inputs();
    check("exc_state_redir", {30'd0, state_dbg}, 1);
    check("exc_inten", {31'd0, IntEn}, 0);
    ctrl_read("exc_epc", 2'd1, 32'h100);
    ctrl_read("exc_code", 2'd2, 3);
    ctrl_read("exc_status", 2'd0, 32'h2);
    // In REDIR, a HALT and an IRQ are both ignored.
    MemEn = 1; MemHalt = 1; IrqReq = 1; #1;
    check("redir_flush", {28'd0, flush}, 0);
    check("redir_stall", {28'd0, stall}, 0);
    step();
    clear_inputs();
    check("redir_to_run", {30'd0, state_dbg}, 0);

    // ERET
    MemEn = 1; MemEret = 1; #1;
    check("eret_flush", {28'd0, flush}, 4'hF);
    check("eret_newpc", {2'd0, NewPC}, 32'h100);
    step();
    clear_inputs();
    check("eret_inten", {31'd0, IntEn}, 1);
    step();

    // MemBusy concurrent with MemExp for 3 cycles.
    for (int i = 0; i < 3; i++) begin
      MemBusy = 1; MemEn = 1; MemExp = 1; MemExpCode = 3'd5; MemPC = 30'h200; #1;
      check("busy_stall", {28'd0, stall}, 4'hF);
      check("busy_flush", {28'd0, flush}, 0);
      step();
      ctrl_read("busy_epc", 2'd1, 32'h100);
    end
    MemBusy = 0; #1;
    check("busy_drop_flush", {28'd0, flush}, 4'hF);
    check("busy_drop_newpc", {2'd0, NewPC}, 32'h40);
    step();
    clear_inputs();
    ctrl_read("busy_epc_after", 2'd1, 32'h200);
    ctrl_read("busy_code", 2'd2, 5);
    ctrl_read("busy_status", 2'd0, 32'h2);
    step();

    // Load hazard with a CtrlWe to EPC in the same cycle.
    LoadHazard = 1; CtrlWe = 1; CtrlAddr = 2'd1; CtrlWrData = 32'h2A; #1;
    check("lh_stall", {28'd0, stall}, 4'b1100);
    check("lh_flush", {28'd0, flush}, 4'b0100);
    step();
    clear_inputs();
    ctrl_read("lh_epc", 2'd1, 32'h2A);

    // MemEn=0 hides MemExp.
    MemExp = 1; MemExpCode = 3'd4; #1;
    check("memen0_flush", {28'd0, flush}, 0);
    step();
    clear_inputs();

    // External IRQ in RUN.
    ctrl_write(2'd0, 32'h1);
    MemEn = 1; IrqReq = 1; MemPC = 30'h55; #1;
    check("irq_flush", {28'd0, flush}, 4'hF);
    check("irq_newpc", {2'd0, NewPC}, 32'h40);
    step();
    clear_inputs();
    ctrl_read("irq_epc", 2'd1, 32'h55);
    ctrl_read("irq_code", 2'd2, 1);
    step();

    // HALT at the top address. IRQ arrives after 4 cycles.
    ctrl_write(2'd0, 32'h1);
    MemEn = 1; MemHalt = 1; MemPC = 30'h3FFF_FFFF; #1;
    check("halt_flush", {28'd0, flush}, 4'b1110);
    check("halt_newpc", {2'd0, NewPC}, 0);
    step();
    clear_inputs();
    for (int i = 0; i < 4; i++) begin
      check("halted", {31'd0, Halted}, 1);
      check("halt_stall", {28'd0, stall}, 4'b1000);
      check("halt_drain", {28'd0, flush}, 4'b0111);
      step();
    end
    IrqReq = 1; #1;
    check("wake_ifflush", {31'd0, IFFlush}, 1);
    check("wake_newpc", {2'd0, NewPC}, 32'h40);
    step();
    clear_inputs();
    check("wake_halted", {31'd0, Halted}, 0);
    check("wake_inten", {31'd0, IntEn}, 0);
    ctrl_read("wake_epc", 2'd1, 0);
    ctrl_read("wake_code", 2'd2, 1);
    check("wake_state", {30'd0, state_dbg}, 1);

    // final report
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
